// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC frequency discriminator.
// Holds the state enum and the phase-wrap rule for the discriminator and its averager.
package cordic_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Folds a phase difference back into [-pi, +pi]. The result is 32 bits
    // wide so that callers of any width can size-cast it down.
    function automatic logic signed [31:0] wrap_phase(
        input logic signed [31:0] d,
        input logic signed [31:0] pi_val
    );
        logic signed [31:0] r;
        r = d;
        if (d > pi_val) begin
            r = d - (pi_val <<< 1);
        end else if (d < -pi_val) begin
            r = d + (pi_val <<< 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/cordic_mavg.sv
// Moving average over 2**AVG_LOG phase increments: circular buffer plus running sum.
// Latency: sum registered one cycle after in_vld; average is a combinational shift of it.
// No backpressure: accepts one sample per cycle; clr zeroes buffer, sum and valid.
module cordic_mavg
    import cordic_pkg::*;
#(
    parameter int W       = 18,
    parameter int AVG_LOG = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                in_vld,
    input  logic signed [W-1:0] in_dat,
    output logic                avg_vld,
    output logic signed [W-1:0] avg_dat
);

    localparam int DEPTH = 1 << AVG_LOG;
    localparam int PTRW  = (AVG_LOG > 0) ? AVG_LOG : 1;
    localparam int SW    = W + AVG_LOG;

    logic signed [W-1:0]  buf_q [DEPTH];
    logic [PTRW-1:0]      ptr_q;
    logic [PTRW-1:0]      ptr_d;
    logic signed [SW-1:0] sum_q;
    logic signed [SW-1:0] sum_d;
    logic                 vld_q;

    // The slot under the pointer holds the oldest entry; it is replaced in place.
    always_comb begin
        sum_d = sum_q + SW'(in_dat) - SW'(buf_q[ptr_q]);
        ptr_d = ptr_q + PTRW'(1);
        if (int'(ptr_q) == DEPTH - 1) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            ptr_q <= '0;
            sum_q <= '0;
            vld_q <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            ptr_q <= '0;
            sum_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_vld;
            if (in_vld) begin
                buf_q[ptr_q] <= in_dat;
                ptr_q        <= ptr_d;
                sum_q        <= sum_d;
            end
        end
    end

    assign avg_vld = vld_q;
    assign avg_dat = W'(sum_q >>> AVG_LOG);

endmodule

// File: rtl/cordic_freq_discr.sv
// Frequency discriminator: wrapped phase difference of successive samples, moving-averaged.
// Latency 2 cycles from st to rdy, fully pipelined; optional squelch via CORDIC_DISCR_SQUELCH_EN.
// No backpressure: one sample per cycle; clr re-primes and discards in-flight results.
module cordic_freq_discr
    import cordic_pkg::*;
#(
    parameter int XY_WIDTH = 16,
    parameter int PI_VAL   = 2 ** XY_WIDTH,
    parameter int AVG_LOG  = 3,
    parameter int MAG_THR  = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       st,
    input  logic [XY_WIDTH-1:0]        mag,
    input  logic signed [XY_WIDTH+1:0] ph,
    output logic                       rdy,
    output logic signed [XY_WIDTH+1:0] freq,
    output logic                       sq
);

    localparam int PW = XY_WIDTH + 2;
    localparam int DW = XY_WIDTH + 3;

    state_t               state_q;
    logic signed [PW-1:0] ph_prev_q;
    logic signed [PW-1:0] d1_q;
    logic                 v1_q;
    logic                 sq1_q;
    logic                 sq2_q;
    logic                 rdy_q;
    logic signed [PW-1:0] freq_q;
    logic                 sq_q;

    logic signed [DW-1:0] d_raw;
    logic signed [PW-1:0] d_new;
    logic                 squelch;
    logic                 avg_vld;
    logic signed [PW-1:0] avg_dat;

    // One extra bit so the raw difference of two full-range phases cannot overflow.
    assign d_raw = DW'(ph) - DW'(ph_prev_q);
    assign d_new = PW'(wrap_phase(32'(d_raw), 32'(PI_VAL)));

`ifdef CORDIC_DISCR_SQUELCH_EN
    assign squelch = (mag < XY_WIDTH'(MAG_THR));
`else
    logic unused_mag;
    assign unused_mag = ^mag;
    assign squelch    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= PRIME;
            ph_prev_q <= '0;
            d1_q      <= '0;
            v1_q      <= 1'b0;
            sq1_q     <= 1'b0;
            sq2_q     <= 1'b0;
            rdy_q     <= 1'b0;
            freq_q    <= '0;
            sq_q      <= 1'b0;
        end else begin
            v1_q  <= 1'b0;
            rdy_q <= 1'b0;
            sq2_q <= sq1_q;
            if (clr) begin
                // A coincident sample becomes the new reference; the averager clears itself.
                state_q <= st ? RUN : PRIME;
                if (st) begin
                    ph_prev_q <= ph;
                end
            end else begin
                if (st) begin
                    ph_prev_q <= ph;
                    state_q   <= RUN;
                    if (state_q == RUN) begin
                        v1_q  <= 1'b1;
                        d1_q  <= squelch ? '0 : d_new;
                        sq1_q <= squelch;
                    end
                end
                if (avg_vld) begin
                    rdy_q  <= 1'b1;
                    freq_q <= avg_dat;
                    sq_q   <= sq2_q;
                end
            end
        end
    end

    cordic_mavg #(
        .W       (PW),
        .AVG_LOG (AVG_LOG)
    ) u_mavg (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .in_vld  (v1_q),
        .in_dat  (d1_q),
        .avg_vld (avg_vld),
        .avg_dat (avg_dat)
    );

    assign rdy  = rdy_q;
    assign freq = freq_q;
    assign sq   = sq_q;

endmodule

// File: tb/tb_cordic_freq_discr.sv
// Bench for cordic_freq_discr: two instances (no averaging and 4-tap averaging) share stimulus.
module tb_cordic_freq_discr;

    localparam int PI = 65536;

    logic               clk   = 1'b0;
    logic               reset = 1'b0;
    logic               clr   = 1'b0;
    logic               st    = 1'b0;
    logic [15:0]        mag   = 16'd1000;
    logic signed [17:0] ph    = '0;

    logic               rdy0, rdy2, sq0, sq2;
    logic signed [17:0] freq0, freq2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int due;
        int f0;
        int f2;
        bit sq;
    } res_t;

    bit   primed;
    int   prev;
    int   win0[$];
    int   win2[$];
    res_t pend[$];
    bit   exp_rdy;
    int   exp_f0, exp_f2;
    bit   exp_sq;

    always #5 clk = ~clk;

    cordic_freq_discr #(.XY_WIDTH(16), .PI_VAL(65536), .AVG_LOG(0), .MAG_THR(64)) dut0 (
        .clk(clk), .reset(reset), .clr(clr), .st(st), .mag(mag), .ph(ph),
        .rdy(rdy0), .freq(freq0), .sq(sq0)
    );

    cordic_freq_discr #(.XY_WIDTH(16), .PI_VAL(65536), .AVG_LOG(2), .MAG_THR(64)) dut2 (
        .clk(clk), .reset(reset), .clr(clr), .st(st), .mag(mag), .ph(ph),
        .rdy(rdy2), .freq(freq2), .sq(sq2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_avg();
        win0 = {0};
        win2 = {0, 0, 0, 0};
    endtask

    task automatic model_reset();
        pend.delete();
        clear_avg();
        primed  = 1'b0;
        prev    = 0;
        exp_rdy = 1'b0;
        exp_f0  = 0;
        exp_f2  = 0;
        exp_sq  = 1'b0;
    endtask

    // Reference behaviour at one rising edge, from the sampled inputs.
    task automatic model_edge();
        int   d;
        int   s0, s2;
        bit   s;
        res_t r;
        cyc++;
        exp_rdy = 1'b0;
        if (clr) begin
            pend.delete();
            clear_avg();
            primed = st;
            if (st) prev = int'(ph);
        end else if (st) begin
            if (!primed) begin
                primed = 1'b1;
                prev   = int'(ph);
            end else begin
                d    = int'(ph) - prev;
                prev = int'(ph);
                if (d > PI) d -= 2 * PI;
                else if (d < -PI) d += 2 * PI;
                s = 1'b0;
`ifdef CORDIC_DISCR_SQUELCH_EN
                if (mag < 16'd64) begin
                    d = 0;
                    s = 1'b1;
                end
`endif
                win0.push_back(d);
                void'(win0.pop_front());
                win2.push_back(d);
                void'(win2.pop_front());
                s0 = 0;
                s2 = 0;
                foreach (win0[i]) s0 += win0[i];
                foreach (win2[i]) s2 += win2[i];
                r.due = cyc + 2;
                r.f0  = s0;
                r.f2  = s2 >>> 2;
                r.sq  = s;
                pend.push_back(r);
            end
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r       = pend.pop_front();
            exp_rdy = 1'b1;
            exp_f0  = r.f0;
            exp_f2  = r.f2;
            exp_sq  = r.sq;
        end
    endtask

    task automatic check_outputs();
        chk("rdy0", int'(rdy0), int'(exp_rdy));
        chk("rdy2", int'(rdy2), int'(exp_rdy));
        chk("freq0", int'(freq0), exp_f0);
        chk("freq2", int'(freq2), exp_f2);
        chk("sq0", int'(sq0), int'(exp_sq));
        chk("sq2", int'(sq2), int'(exp_sq));
    endtask

    task automatic step(input bit s, input int p, input int m, input bit c);
        st  = s;
        ph  = 18'(p);
        mag = 16'(m);
        clr = c;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        st  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        chk("reset_rdy", int'(rdy0) + int'(rdy2), 0);
        chk("reset_freq0", int'(freq0), 0);
        chk("reset_freq2", int'(freq2), 0);
        chk("reset_sq", int'(sq0) + int'(sq2), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int got[$];
        int exp_ramp[6];
        exp_ramp = '{100, 200, 300, 400, 400, 400};
        model_reset();
        #1;
        do_reset();

        // First sample only primes; the second yields its increment two cycles later.
        step(1, 1000, 1000, 0);
        step(1, 1500, 1000, 0);
        step(0, 0, 1000, 0);
        chk("first_no_rdy_yet", int'(rdy0), 0);
        step(0, 0, 1000, 0);
        chk("req030_rdy", int'(rdy0), 1);
        chk("req030_freq", int'(freq0), 500);

        // Wrap-around in both directions.
        step(1, 60000, 1000, 0);
        step(1, -60000, 1000, 0);
        step(1, 60000, 1000, 0);
        step(0, 0, 1000, 0);
        chk("wrap_pos", int'(freq0), 11072);
        step(0, 0, 1000, 0);
        chk("wrap_neg", int'(freq0), -11072);
        step(0, 0, 1000, 0);
        chk("freq_hold", int'(freq0), -11072);
        chk("rdy_pulse", int'(rdy0), 0);

        // Averaging ramp after re-prime with ph=0.
        step(1, 0, 1000, 1);
        for (int i = 1; i <= 8; i++) begin
            step(i <= 6, 400 * i, 1000, 0);
            if (rdy2) got.push_back(int'(freq2));
        end
        chk("ramp_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) chk("ramp_val", got[i], exp_ramp[i]);

        // clr mid-stream suppresses the pending result.
        step(1, 6000, 1000, 0);
        step(1, 7000, 1000, 1);
        step(0, 0, 1000, 0);
        chk("clr_suppress", int'(rdy0), 0);
        step(1, 7300, 1000, 0);
        step(0, 0, 1000, 0);
        step(0, 0, 1000, 0);
        chk("clr_rdy", int'(rdy0), 1);
        chk("clr_freq", int'(freq0), 300);

        // Reset with results in flight.
        step(1, 100, 1000, 0);
        step(1, 300, 1000, 0);
        do_reset();
        step(0, 0, 1000, 0);
        chk("rst_drop_rdy", int'(rdy0), 0);
        step(1, 5000, 1000, 0);
        step(0, 0, 1000, 0);
        step(0, 0, 1000, 0);
        chk("rst_prime_only", int'(rdy0), 0);
        step(1, 5200, 1000, 0);
        step(0, 0, 1000, 0);
        step(0, 0, 1000, 0);
        chk("rst_after_freq", int'(freq0), 200);

        // Low-magnitude sample followed by a normal one.
        step(1, 0, 1000, 1);
        step(1, 500, 10, 0);
        step(1, 1000, 1000, 0);
        step(0, 0, 1000, 0);
`ifdef CORDIC_DISCR_SQUELCH_EN
        chk("squelch_freq", int'(freq0), 0);
        chk("squelch_sq", int'(sq0), 1);
`else
        chk("nosquelch_freq", int'(freq0), 500);
        chk("nosquelch_sq", int'(sq0), 0);
`endif
        step(0, 0, 1000, 0);
        chk("after_squelch_freq", int'(freq0), 500);
        chk("after_squelch_sq", int'(sq0), 0);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 262143)) - 131072,
                 int'($urandom_range(0, 127)),
                 $urandom_range(0, 31) == 0);
        end
        for (int n = 0; n < 4; n++) step(0, 0, 1000, 0);
        chk("pending_drained", pend.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
